imc_row_controller: RTL and testbench



---
 rtl/imc_row_controller.sv | 187 ++++++++++++++++++
 tb/tb_imc_row_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imc_row_controller.sv
// ============================================================================
// imc_row_controller : request sequencer for the 128-row dual-read/single-write
//                      SRAM array (read, write, in-memory compute)
// Revision 1.0
// ============================================================================
`default_nettype none

module imc_row_controller #(
   parameter int ADDR_W       = 7,
   parameter int WIDTH        = 32,
   parameter int SENSE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [1:0]        req_fn,
   input  logic [ADDR_W-1:0] req_src1,
   input  logic [ADDR_W-1:0] req_src2,
   input  logic [ADDR_W-1:0] req_dst,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic [ADDR_W-1:0] read_address1,
   output logic [ADDR_W-1:0] read_address2,
   output logic [ADDR_W-1:0] write_address,
   output logic              read_enable1,
   output logic              read_enable2,
   output logic              write_enable,
   output logic [WIDTH-1:0]  wr_data,
   input  logic [WIDTH-1:0]  sa_data1,
   input  logic [WIDTH-1:0]  sa_data2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_ACT  = 2'd1;
   localparam logic [1:0] c_ST_WB   = 2'd2;
   localparam logic [1:0] c_ST_RESP = 2'd3;

   localparam logic [1:0] c_OP_READ    = 2'b00;
   localparam logic [1:0] c_OP_WRITE   = 2'b01;
   localparam logic [1:0] c_OP_COMPUTE = 2'b10;

   localparam logic [3:0] c_CNT_INIT = 4'(SENSE_CYCLES - 1);

   logic [1:0]        r_state;
   logic [1:0]        r_op;
   logic [1:0]        r_fn;
   logic [3:0]        r_cnt;
   logic              r_req_ready;
   logic              r_busy;
   logic [ADDR_W-1:0] r_ra1;
   logic [ADDR_W-1:0] r_ra2;
   logic [ADDR_W-1:0] r_wa;
   logic              r_re1;
   logic              r_re2;
   logic              r_we;
   logic [WIDTH-1:0]  r_wr_data;
   logic              r_rsp_valid;
   logic [WIDTH-1:0]  r_rsp_data;
   logic              r_rsp_err;
   logic [WIDTH-1:0]  w_result;

   always_comb begin
      w_result = '0;
      case (r_fn)
         2'b00:   w_result = sa_data1 & sa_data2;
         2'b01:   w_result = sa_data1 | sa_data2;
         2'b10:   w_result = sa_data1 ^ sa_data2;
         default: w_result = ~sa_data1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_op        <= '0;
         r_fn        <= '0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_ra1       <= '0;
         r_ra2       <= '0;
         r_wa        <= '0;
         r_re1       <= 1'b0;
         r_re2       <= 1'b0;
         r_we        <= 1'b0;
         r_wr_data   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (req_valid) begin
                  r_op        <= req_op;
                  r_fn        <= req_fn;
                  r_ra1       <= req_src1;
                  r_ra2       <= req_src2;
                  r_wa        <= req_dst;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  case (req_op)
                     c_OP_READ: begin
                        r_re1   <= 1'b1;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_ST_ACT;
                     end
                     c_OP_COMPUTE: begin
                        r_re1   <= 1'b1;
                        r_re2   <= 1'b1;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_ST_ACT;
                     end
                     c_OP_WRITE: begin
                        r_we      <= 1'b1;
                        r_wr_data <= req_wdata;
                        r_state   <= c_ST_WB;
                     end
                     default: begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= c_ST_RESP;
                     end
                  endcase
               end
            end
            c_ST_ACT: begin
               // Sense data is sampled on the edge that closes the last wordline cycle.
               if (r_cnt == 4'd0) begin
                  r_re1 <= 1'b0;
                  r_re2 <= 1'b0;
                  if (r_op == c_OP_COMPUTE) begin
                     r_we      <= 1'b1;
                     r_wr_data <= w_result;
                     r_state   <= c_ST_WB;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_rsp_data  <= sa_data1;
                     r_state     <= c_ST_RESP;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_ST_WB: begin
               r_we        <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= (r_op == c_OP_COMPUTE) ? r_wr_data : '0;
               r_state     <= c_ST_RESP;
            end
            default: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= c_ST_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign busy          = r_busy;
   assign read_address1 = r_ra1;
   assign read_address2 = r_ra2;
   assign write_address = r_wa;
   assign read_enable1  = r_re1;
   assign read_enable2  = r_re2;
   assign write_enable  = r_we;
   assign wr_data       = r_wr_data;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign rsp_err       = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_imc_row_controller.sv
// ============================================================================
// tb_imc_row_controller : directed bench for imc_row_controller with a small
//                         behavioural SRAM array behind the decoder ports
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imc_row_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [1:0]  req_fn = '0;
   logic [6:0]  req_src1 = '0;
   logic [6:0]  req_src2 = '0;
   logic [6:0]  req_dst = '0;
   logic [31:0] req_wdata = '0;
   logic [6:0]  read_address1, read_address2, write_address;
   logic        read_enable1, read_enable2, write_enable;
   logic [31:0] wr_data;
   logic [31:0] sa_data1, sa_data2;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_overlap = 0;
   int n_we      = 0;

   logic [31:0] mem [0:127];

   imc_row_controller #(.ADDR_W(7), .WIDTH(32), .SENSE_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_fn(req_fn),
      .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wdata(req_wdata),
      .read_address1(read_address1), .read_address2(read_address2), .write_address(write_address),
      .read_enable1(read_enable1), .read_enable2(read_enable2), .write_enable(write_enable),
      .wr_data(wr_data), .sa_data1(sa_data1), .sa_data2(sa_data2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Array model: sense amps show the addressed row while its wordline is up.
   assign sa_data1 = read_enable1 ? mem[read_address1] : '0;
   assign sa_data2 = read_enable2 ? mem[read_address2] : '0;

   always @(posedge clk) begin
      if (write_enable) mem[write_address] <= wr_data;
   end

   always @(negedge clk) begin
      if (write_enable && (read_enable1 || read_enable2)) n_overlap++;
      if (write_enable) n_we++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] fn, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] d, input logic [31:0] wd);
      req_valid = 1'b1; req_op = op; req_fn = fn;
      req_src1 = s1; req_src2 = s2; req_dst = d; req_wdata = wd;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_checks++; if (read_enable1 !== 1'b0) begin n_fail++; $display("FAIL reset_re1: got %0b expected 0", read_enable1); end
      n_checks++; if (read_enable2 !== 1'b0) begin n_fail++; $display("FAIL reset_re2: got %0b expected 0", read_enable2); end
      n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", write_enable); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %0b expected 0", rsp_err); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_checks++; if ({read_address1, read_address2, write_address, wr_data, rsp_data} !== '0) begin
         n_fail++; $display("FAIL reset_data: got nonzero address/data expected all 0");
      end
   endtask

   task automatic test_write();
      rsp_ready = 1'b1;
      issue(2'b01, 2'b00, 7'd0, 7'd0, 7'd5, 32'hDEADBEEF);
      // cycle 1
      n_checks++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL wr_we_c1: got %0b expected 1", write_enable); end
      n_checks++; if (write_address !== 7'd5) begin n_fail++; $display("FAIL wr_addr: got %0d expected 5", write_address); end
      n_checks++; if (wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h expected deadbeef", wr_data); end
      n_checks++; if ({read_enable1, read_enable2, rsp_valid, req_ready, busy} !== 5'b00001) begin
         n_fail++; $display("FAIL wr_ctrl_c1: got %b expected 00001", {read_enable1, read_enable2, rsp_valid, req_ready, busy});
      end
      tick(); // cycle 2
      n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL wr_we_c2: got %0b expected 0", write_enable); end
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid: got %0b expected 1", rsp_valid); end
      n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_data: got %h expected 0", rsp_data); end
      n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_err: got %0b expected 0", rsp_err); end
      tick(); // handshake done
      n_checks++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         n_fail++; $display("FAIL wr_idle: got %b expected 010", {rsp_valid, req_ready, busy});
      end
   endtask

   task automatic test_read();
      issue(2'b00, 2'b00, 7'd5, 7'd9, 7'd0, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         n_checks++; if ({read_enable1, read_enable2, write_enable} !== 3'b100) begin
            n_fail++; $display("FAIL rd_enables_c%0d: got %b expected 100", c, {read_enable1, read_enable2, write_enable});
         end
         n_checks++; if (read_address1 !== 7'd5) begin n_fail++; $display("FAIL rd_addr_c%0d: got %0d expected 5", c, read_address1); end
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rsp_c%0d: got %0b expected 0", c, rsp_valid); end
         tick();
      end
      // cycle 3
      n_checks++; if (read_enable1 !== 1'b0) begin n_fail++; $display("FAIL rd_re1_c3: got %0b expected 0", read_enable1); end
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %0b expected 1", rsp_valid); end
      n_checks++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp_data: got %h expected deadbeef", rsp_data); end
      tick();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_idle: got %0b expected 1", req_ready); end
   endtask

   task automatic test_compute();
      issue(2'b01, 2'b00, 7'd0, 7'd0, 7'd3, 32'hFF00FF00); tick(); tick();
      issue(2'b01, 2'b00, 7'd0, 7'd0, 7'd4, 32'h0FF00FF0); tick(); tick();
      issue(2'b10, 2'b10, 7'd3, 7'd4, 7'd3, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         n_checks++; if ({read_enable1, read_enable2, write_enable} !== 3'b110) begin
            n_fail++; $display("FAIL cmp_enables_c%0d: got %b expected 110", c, {read_enable1, read_enable2, write_enable});
         end
         n_checks++; if ({read_address1, read_address2} !== {7'd3, 7'd4}) begin
            n_fail++; $display("FAIL cmp_addr_c%0d: got %0d/%0d expected 3/4", c, read_address1, read_address2);
         end
         tick();
      end
      // cycle 3: write-back
      n_checks++; if ({read_enable1, read_enable2, write_enable} !== 3'b001) begin
         n_fail++; $display("FAIL cmp_wb_enables: got %b expected 001", {read_enable1, read_enable2, write_enable});
      end
      n_checks++; if (write_address !== 7'd3) begin n_fail++; $display("FAIL cmp_wb_addr: got %0d expected 3", write_address); end
      n_checks++; if (wr_data !== 32'hF0F0F0F0) begin n_fail++; $display("FAIL cmp_wb_data: got %h expected f0f0f0f0", wr_data); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL cmp_early_rsp: got %0b expected 0", rsp_valid); end
      tick(); // cycle 4
      n_checks++; if ({rsp_valid, write_enable} !== 2'b10) begin
         n_fail++; $display("FAIL cmp_rsp_c4: got %b expected 10", {rsp_valid, write_enable});
      end
      n_checks++; if (rsp_data !== 32'hF0F0F0F0) begin n_fail++; $display("FAIL cmp_rsp_data: got %h expected f0f0f0f0", rsp_data); end
      tick();
      n_checks++; if (mem[3] !== 32'hF0F0F0F0) begin n_fail++; $display("FAIL cmp_row3: got %h expected f0f0f0f0", mem[3]); end
   endtask

   task automatic test_compute_fns();
      // Row 3 = F0F0F0F0, row 4 = 0FF00FF0 at this point.
      logic [1:0]  fns  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      logic [6:0]  s1s  [4] = '{7'd3, 7'd3, 7'd3, 7'd4};
      logic [31:0] exps [4] = '{32'h00F000F0, 32'hFFF0FFF0, 32'h0F0F0F0F, 32'h00000000};
      for (int i = 0; i < 4; i++) begin
         issue(2'b10, fns[i], s1s[i], 7'd4, 7'(10 + i), 32'h0);
         tick(); tick(); // cycle 3
         n_checks++; if ({write_enable, wr_data} !== {1'b1, exps[i]}) begin
            n_fail++; $display("FAIL fn%0d_wb: got we=%0b data=%h expected we=1 data=%h", i, write_enable, wr_data, exps[i]);
         end
         tick(); // cycle 4
         n_checks++; if ({rsp_valid, rsp_data} !== {1'b1, exps[i]}) begin
            n_fail++; $display("FAIL fn%0d_rsp: got valid=%0b data=%h expected valid=1 data=%h", i, rsp_valid, rsp_data, exps[i]);
         end
         tick();
      end
   endtask

   task automatic test_illegal_backpressure();
      rsp_ready = 1'b0;
      issue(2'b11, 2'b00, 7'd1, 7'd2, 7'd3, 32'h12345678);
      n_checks++; if ({rsp_valid, rsp_err} !== 2'b11) begin
         n_fail++; $display("FAIL ill_rsp_c1: got %b expected 11", {rsp_valid, rsp_err});
      end
      n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL ill_rsp_data: got %h expected 0", rsp_data); end
      for (int c = 0; c < 5; c++) begin
         n_checks++; if ({read_enable1, read_enable2, write_enable, req_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL ill_hold%0d_ctrl: got %b expected 0000", c, {read_enable1, read_enable2, write_enable, req_ready});
         end
         n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL ill_hold%0d_rsp: got valid=%0b err=%0b data=%h expected 1/1/0", c, rsp_valid, rsp_err, rsp_data);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      n_checks++; if ({rsp_valid, rsp_err, req_ready, busy} !== 4'b0010) begin
         n_fail++; $display("FAIL ill_release: got %b expected 0010", {rsp_valid, rsp_err, req_ready, busy});
      end
   endtask

   task automatic test_reset_mid_compute();
      int we_before;
      issue(2'b01, 2'b00, 7'd0, 7'd0, 7'd7, 32'h12345678); tick(); tick();
      issue(2'b10, 2'b00, 7'd3, 7'd4, 7'd7, 32'h0);
      we_before = n_we;
      n_checks++; if ({read_enable1, read_enable2} !== 2'b11) begin
         n_fail++; $display("FAIL rstmid_act: got %b expected 11", {read_enable1, read_enable2});
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if ({read_enable1, read_enable2, write_enable} !== 3'b000) begin
         n_fail++; $display("FAIL rstmid_enables: got %b expected 000", {read_enable1, read_enable2, write_enable});
      end
      for (int c = 0; c < 6; c++) tick();
      n_checks++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         n_fail++; $display("FAIL rstmid_idle: got %b expected 010", {rsp_valid, req_ready, busy});
      end
      n_checks++; if (n_we !== we_before) begin n_fail++; $display("FAIL rstmid_no_write: got %0d write cycles expected 0", n_we - we_before); end
      n_checks++; if (mem[7] !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_row7: got %h expected 12345678", mem[7]); end
   endtask

   task automatic test_back_to_back();
      // Accept on the edge right after the handshake edge.
      issue(2'b01, 2'b00, 7'd0, 7'd0, 7'd20, 32'hA5A5A5A5);
      tick(); tick();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b expected 1", req_ready); end
      issue(2'b00, 2'b00, 7'd20, 7'd0, 7'd0, 32'h0);
      tick(); tick();
      n_checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hA5A5A5A5}) begin
         n_fail++; $display("FAIL b2b_read: got valid=%0b data=%h expected 1/a5a5a5a5", rsp_valid, rsp_data);
      end
      tick();
      n_checks++; if (n_overlap !== 0) begin n_fail++; $display("FAIL no_overlap: got %0d overlap cycles expected 0", n_overlap); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_compute();
      test_compute_fns();
      test_illegal_backpressure();
      test_reset_mid_compute();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
